// File: rtl/pair_match_pkg.sv
// Shared types and helpers for the pair-match frame counter.
// The pair-match function lives here so cell and bench agree on it.
package pair_match_pkg;

    localparam int DEFAULT_FRAME_LEN = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    // Pair matches unless both bit positions differ.
    function automatic logic pair_match(
        input logic x1,
        input logic x2,
        input logic y1,
        input logic y2
    );
        return (x1 == y1) | (x2 == y2);
    endfunction

endpackage

// File: rtl/pair_match_cell.sv
// Combinational pair-match cell: m = (x1 == y1) | (x2 == y2).
// Kept as its own module so the match logic is a single instance.
module pair_match_cell
    import pair_match_pkg::*;
(
    input  logic x1,
    input  logic x2,
    input  logic y1,
    input  logic y2,
    output logic m
);

    assign m = pair_match(x1, x2, y1, y2);

endmodule

// File: rtl/pair_match_counter.sv
// Counts pair matches over frames of FRAME_LEN pairs, reports per frame.
// Optional mismatch_cnt output: define PAIR_MATCH_MISMATCH_CNT_EN.
module pair_match_counter
    import pair_match_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x1,
    input  logic             x2,
    input  logic             y1,
    input  logic             y2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] match_cnt,
    output logic             all_match
`ifdef PAIR_MATCH_MISMATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] mismatch_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_sum;
    logic             m;
    logic             in_hs;
    logic             last_hs;

    pair_match_cell u_cell (
        .x1 (x1),
        .x2 (x2),
        .y1 (y1),
        .y2 (y2),
        .m  (m)
    );

    assign in_hs   = in_valid & in_ready;
    assign last_hs = in_hs & (idx_q == LAST);
    assign acc_sum = acc_q + (m ? ONE : '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode from registered state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (last_hs) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Frame counters and result register; the result loads on the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            acc_q     <= '0;
            match_cnt <= '0;
            all_match <= 1'b0;
        end else if (in_hs) begin
            if (last_hs) begin
                idx_q     <= '0;
                acc_q     <= '0;
                match_cnt <= acc_sum;
                all_match <= (acc_sum == FULL);
            end else begin
                idx_q <= idx_q + ONE;
                acc_q <= acc_sum;
            end
        end
    end

`ifdef PAIR_MATCH_MISMATCH_CNT_EN
    logic [CNT_W-1:0] mis_q;
    logic [CNT_W-1:0] mis_sum;

    assign mis_sum = mis_q + (m ? '0 : ONE);

    // Independent mismatch accumulator, registered with match_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q        <= '0;
            mismatch_cnt <= '0;
        end else if (in_hs) begin
            if (last_hs) begin
                mis_q        <= '0;
                mismatch_cnt <= mis_sum;
            end else begin
                mis_q <= mis_sum;
            end
        end
    end
`endif

endmodule

// File: doc/pair_match_counter.md
# pair_match_counter

Frame-level accumulator for the two-bit pair-match stage. Accepts a stream of (x1, x2, y1, y2) pairs over a valid/ready handshake. Evaluates the pair-match function for each accepted pair and counts matches over a frame of FRAME_LEN pairs. Presents the count downstream on a second valid/ready handshake. It sits directly downstream of the combinational pair-match logic, turning per-pair results into per-frame statistics.

## Interface
- FRAME_LEN, 8: pairs per frame; legal range 1..255
- CNT_W, $clog2(FRAME_LEN+1): width of count outputs
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  upstream pair valid
- in_ready  output  1  block can accept a pair
- x1, x2, y1, y2  input  1 each  pair operands
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- match_cnt  output  CNT_W  number of matching pairs in the frame
- all_match  output  1  match_cnt == FRAME_LEN
- mismatch_cnt  output  CNT_W  present only with MISMATCH_CNT_EN

## Operation
- Pair match: m = (x1 == y1) | (x2 == y2).
  - m is 1 when either bit position agrees.
  - m is 0 only when both bit positions differ.
- Two-state FSM: ACCUM and REPORT. Reset state is ACCUM.
- ACCUM:
  - in_ready = 1.
  - An input handshake (in_valid & in_ready) samples the operands.
  - On each handshake: idx += 1 and acc += m.
  - Operands are ignored when no handshake occurs.
  - On the handshake where idx == FRAME_LEN-1, the FSM moves to REPORT. match_cnt loads the final acc including that pair; idx and acc clear to 0.
- REPORT:
  - out_valid = 1 and in_ready = 0.
  - match_cnt and all_match are stable until an output handshake (out_valid & out_ready).
  - On the output handshake, the FSM returns to ACCUM.
- Counters never wrap: idx ≤ FRAME_LEN-1 and acc ≤ FRAME_LEN, both held in CNT_W bits.
- Reset values, all outputs: in_ready 1 (combinational from state, so 1 during reset), out_valid 0, match_cnt 0, all_match 0, mismatch_cnt 0.
- Reset mid-frame discards the partial frame. Reset in REPORT drops the pending result.

## Timing
- in_ready and out_valid are decoded from registered state only; there are no combinational paths from in_valid or out_ready.
- Result latency: out_valid rises 1 cycle after the last pair's handshake edge.
- After an output handshake at edge N, in_ready is 1 from edge N onward. The earliest next pair is accepted at edge N+1.
- Peak throughput: FRAME_LEN+1 cycles per frame.
- in_valid held high during REPORT: no pair is consumed; the same pair is accepted on the first ACCUM cycle.
- out_ready high before out_valid has no effect. out_ready held high consumes the result in its first REPORT cycle.
- FRAME_LEN = 1: every handshake goes directly to REPORT; match_cnt equals m of that pair.

## Configuration
- Macro: PAIR_MATCH_MISMATCH_CNT_EN.
- Defined:
  - mismatch_cnt port exists and is registered alongside match_cnt.
  - mismatch_cnt = FRAME_LEN - match_cnt, computed from the frame's pairs by a separate accumulator, not by subtraction.
  - Reset value 0; stable in REPORT.
- Undefined: the port, its accumulator and its register are absent. All other behaviour is identical.

## Structure
- Package pair_match_pkg holds:
  - state typedef (ACCUM, REPORT)
  - function pair_match(x1, x2, y1, y2)
  - default FRAME_LEN constant
- Sub-module pair_match_cell computes m and is instantiated once. The rest of the block is flat: FSM, idx/acc counters and the output register.

## Test plan
- Reset, FRAME_LEN=4: during and after rst_n low, in_ready=1, out_valid=0, match_cnt=0. Assert rst_n low mid-cycle (asynchronous): outputs clear without a clock edge.
- Four pairs back-to-back:
  - (x1,x2,y1,y2) = (1,0,1,1), (0,0,1,1), (0,1,1,1), (1,1,0,0).
  - Expect out_valid 1 cycle after the 4th handshake, match_cnt=2, all_match=0, mismatch_cnt=2 when enabled.
- Four pairs of (1,1,1,0) with out_ready=0 for 5 cycles:
  - out_valid held; match_cnt=4 and all_match=1 stable.
  - in_ready=0 throughout.
  - After out_ready, the next pair is accepted the following cycle.
- Gaps: in_valid toggled 1,0,1,0,... with changing operands while low. Only sampled pairs count; the result equals the same sequence sent without gaps.
- Reset after 2 accepted pairs: the next frame of 4 non-matching (0,0,1,1) pairs yields match_cnt=0, with no carry-over.
- FRAME_LEN=1 continuous stream with out_ready=1: one result every 2 cycles; match_cnt alternates per pair value.
